// File: rtl/trigger_event_packer.sv
// Frames trigger-gated TDS words into header/data/trailer events buffered in a FWFT FIFO.
// Writes are visible one cycle later; reads stall on out_ready, and gates without FIFO room are dropped whole.

module tep_fifo #(
    parameter int AW = 9,
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_vld,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_rdy,
    output logic          rd_vld,
    output logic [DW-1:0] rd_dat,
    output logic [AW:0]   count
);
    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_rd;
    logic          do_wr;

    assign do_rd = rd_rdy && (count_q != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_wr = wr_vld && ((count_q != DEPTH) || do_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_wr && !do_rd)      count_q <= count_q + CNT_ONE;
            else if (!do_wr && do_rd) count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_vld = (count_q != '0);
    assign rd_dat = rd_vld ? mem_q[rd_ptr_q] : '0;
    assign count  = count_q;
endmodule

module trigger_event_packer #(
    parameter int DEPTH_LOG2 = 9,
    parameter int MAX_WORDS  = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trigger,
    input  logic [31:0] data_in,
    input  logic        data_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [15:0] event_count,
    output logic [15:0] overflow_count,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DROP    = 2'd2
    } state_t;

    localparam logic [DEPTH_LOG2:0] DEPTH  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] TWO    = {{(DEPTH_LOG2-1){1'b0}}, 2'b10};
    localparam logic [15:0]         MAX_WC = 16'(MAX_WORDS);

    state_t              state_q;
    logic                trig_q;
    logic [15:0]         wc_q;
    logic                trunc_q;
    logic [15:0]         event_count_q;
    logic [15:0]         overflow_count_q;

    logic [DEPTH_LOG2:0] fifo_count;
    logic [DEPTH_LOG2:0] free;
    logic                room2;
    logic                word_ok;
    logic                trig_rise;
    logic                wr_vld;
    logic [32:0]         wr_dat;
    logic [32:0]         rd_dat;

    assign trig_rise = trigger && !trig_q;
    // Room is judged on the registered fill level; a same-cycle read does not help.
    assign free      = DEPTH - fifo_count;
    assign room2     = (free >= TWO);
    assign word_ok   = room2 && (wc_q < MAX_WC);

    always_comb begin
        wr_vld = 1'b0;
        wr_dat = '0;
        case (state_q)
            IDLE: begin
                if (trig_rise && room2) begin
                    wr_vld = 1'b1;
                    wr_dat = {1'b0, 8'hA5, 8'h00, event_count_q};
                end
            end
            CAPTURE: begin
                if (!trigger) begin
                    wr_vld = 1'b1;
                    wr_dat = {1'b1, 8'h5A, 7'b0, trunc_q, wc_q};
                end else if (data_valid && word_ok) begin
                    wr_vld = 1'b1;
                    wr_dat = {1'b0, data_in};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            trig_q           <= 1'b1;
            wc_q             <= '0;
            trunc_q          <= 1'b0;
            event_count_q    <= '0;
            overflow_count_q <= '0;
        end else begin
            trig_q <= trigger;
            case (state_q)
                IDLE: begin
                    if (trig_rise) begin
                        if (room2) begin
                            event_count_q <= event_count_q + 16'd1;
                            wc_q          <= '0;
                            trunc_q       <= 1'b0;
                            state_q       <= CAPTURE;
                        end else begin
                            if (overflow_count_q != 16'hFFFF)
                                overflow_count_q <= overflow_count_q + 16'd1;
                            state_q <= DROP;
                        end
                    end
                end
                CAPTURE: begin
                    if (!trigger) begin
                        state_q <= IDLE;
                    end else if (data_valid) begin
                        if (word_ok) wc_q    <= wc_q + 16'd1;
                        else         trunc_q <= 1'b1;
                    end
                end
                DROP: begin
                    if (!trigger) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tep_fifo #(
        .AW (DEPTH_LOG2),
        .DW (33)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (wr_vld),
        .wr_dat (wr_dat),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat (rd_dat),
        .count  (fifo_count)
    );

    assign out_data       = rd_dat[31:0];
    assign out_last       = rd_dat[32];
    assign event_count    = event_count_q;
    assign overflow_count = overflow_count_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_trigger_event_packer.sv
// Bench for trigger_event_packer: three parameterisations share one stimulus stream.
// Index 0 = defaults, 1 = 16-entry FIFO (random model target), 2 = MAX_WORDS of 8.
module tb_trigger_event_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        trigger;
    logic [31:0] data_in;
    logic        data_valid;
    logic        out_ready;

    logic [31:0] od [3];
    logic        ov [3];
    logic        ol [3];
    logic        ob [3];
    logic [15:0] oe [3];
    logic [15:0] oo [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trigger_event_packer u_def (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .data_in(data_in), .data_valid(data_valid),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_last(ol[0]),
        .event_count(oe[0]), .overflow_count(oo[0]), .busy(ob[0]));

    trigger_event_packer #(.DEPTH_LOG2(4), .MAX_WORDS(1023)) u_d4 (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .data_in(data_in), .data_valid(data_valid),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_last(ol[1]),
        .event_count(oe[1]), .overflow_count(oo[1]), .busy(ob[1]));

    trigger_event_packer #(.DEPTH_LOG2(9), .MAX_WORDS(8)) u_m8 (
        .clk(clk), .rst_n(rst_n), .trigger(trigger), .data_in(data_in), .data_valid(data_valid),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_last(ol[2]),
        .event_count(oe[2]), .overflow_count(oo[2]), .busy(ob[2]));

    // Reference model of the 16-entry instance: FIFO contents as a queue of {last, data}.
    localparam int M_DEPTH = 16;
    localparam int M_MAXW  = 1023;
    logic [32:0] mq [$];
    int          m_mode;   // 0 idle, 1 capturing, 2 dropping
    logic        m_trig;
    int          m_wc;
    logic        m_trunc;
    logic [15:0] m_ev;
    logic [15:0] m_ov;
    logic        model_chk = 1'b0;

    logic [32:0] expq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic t, input logic dv, input logic [31:0] d,
                              input logic rdy, input logic rn);
        int          free;
        logic        rd;
        logic        wr;
        logic [32:0] w;
        if (!rn) begin
            mq.delete();
            m_mode = 0; m_trig = 1'b1; m_wc = 0; m_trunc = 1'b0; m_ev = '0; m_ov = '0;
            return;
        end
        free = M_DEPTH - mq.size();
        rd   = rdy && (mq.size() != 0);
        wr   = 1'b0;
        w    = '0;
        if (m_mode == 0) begin
            if (t && !m_trig) begin
                if (free >= 2) begin
                    wr = 1'b1; w = {1'b0, 8'hA5, 8'h00, m_ev};
                    m_ev = m_ev + 16'd1; m_wc = 0; m_trunc = 1'b0; m_mode = 1;
                end else begin
                    if (m_ov != 16'hFFFF) m_ov = m_ov + 16'd1;
                    m_mode = 2;
                end
            end
        end else if (m_mode == 1) begin
            if (!t) begin
                wr = 1'b1; w = {1'b1, 8'h5A, 7'b0, m_trunc, 16'(m_wc)}; m_mode = 0;
            end else if (dv) begin
                if (free >= 2 && m_wc < M_MAXW) begin
                    wr = 1'b1; w = {1'b0, d}; m_wc++;
                end else begin
                    m_trunc = 1'b1;
                end
            end
        end else if (!t) begin
            m_mode = 0;
        end
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(w);
        m_trig = t;
    endtask

    task automatic model_cmp();
        logic mv;
        mv = (mq.size() != 0);
        check("rnd_valid", 32'(ov[1]), 32'(mv));
        if (mv) begin
            check("rnd_data", od[1], mq[0][31:0]);
            check("rnd_last", 32'(ol[1]), 32'(mq[0][32]));
        end
        check("rnd_evcnt", 32'(oe[1]), 32'(m_ev));
        check("rnd_ovcnt", 32'(oo[1]), 32'(m_ov));
        check("rnd_busy", 32'(ob[1]), 32'(m_mode != 0));
    endtask

    // On return the inputs for this cycle are applied and outputs show this cycle's state.
    task automatic step(input logic t, input logic dv, input logic [31:0] d,
                        input logic rdy, input logic rn);
        @(negedge clk);
        if (model_chk) model_cmp();
        trigger = t; data_valid = dv; data_in = d; out_ready = rdy; rst_n = rn;
        model_step(t, dv, d, rdy, rn);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int u, input string name);
        int n;
        n = expq.size();
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            check({name, "_valid"}, 32'(ov[u]), 32'h1);
            check({name, "_data"}, od[u], expq[k][31:0]);
            check({name, "_last"}, 32'(ol[u]), 32'(expq[k][32]));
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check({name, "_empty"}, 32'(ov[u]), 32'h0);
    endtask

    typedef struct {
        logic        t;
        logic        dv;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic        el;
        logic        eb;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [9];

    initial begin
        logic rt;
        logic rphase;
        logic seen_valid;

        rst_n = 1'b0; trigger = 1'b0; data_in = '0; data_valid = 1'b0; out_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", 32'(ov[0]), 32'h0);
        check("rst_last", 32'(ol[0]), 32'h0);
        check("rst_data", od[0], 32'h0);
        check("rst_evcnt", 32'(oe[0]), 32'h0);
        check("rst_ovcnt", 32'(oo[0]), 32'h0);
        check("rst_busy", 32'(ob[0]), 32'h0);

        // Basic event: gate high 5 cycles, data 0x100+k, consumer always ready
        tbl[0] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h101, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5000000};
        tbl[3] = '{1'b1, 1'b1, 32'h102, 1'b1, 1'b1, 1'b0, 1'b1, 32'h101};
        tbl[4] = '{1'b1, 1'b1, 32'h103, 1'b1, 1'b1, 1'b0, 1'b1, 32'h102};
        tbl[5] = '{1'b1, 1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 1'b1, 32'h103};
        tbl[6] = '{1'b0, 1'b1, 32'h1FF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h104};
        tbl[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 1'b0, 32'h5A000004};
        tbl[8] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].t, tbl[i].dv, tbl[i].d, tbl[i].rdy, 1'b1);
            check($sformatf("basic_valid[%0d]", i), 32'(ov[0]), 32'(tbl[i].ev));
            check($sformatf("basic_busy[%0d]", i), 32'(ob[0]), 32'(tbl[i].eb));
            if (tbl[i].ev) begin
                check($sformatf("basic_data[%0d]", i), od[0], tbl[i].ed);
                check($sformatf("basic_last[%0d]", i), 32'(ol[0]), 32'(tbl[i].el));
            end
        end
        check("basic_evcnt", 32'(oe[0]), 32'h1);

        // Gate held high from reset never forms an event
        step(1'b1, 1'b1, 32'h0, 1'b1, 1'b0);
        seen_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b1, $urandom, 1'b1, 1'b1);
            if (ov[0] || ob[0]) seen_valid = 1'b1;
        end
        check("held_activity", 32'(seen_valid), 32'h0);
        check("held_valid", 32'(ov[0]), 32'h0);
        check("held_evcnt", 32'(oe[0]), 32'h0);
        check("held_busy", 32'(ob[0]), 32'h0);

        // 16-entry FIFO filled with the consumer stalled, then a dropped gate
        do_reset();
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 32'h200 + 32'(k), 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("fill_evcnt", 32'(oe[1]), 32'h1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h2F0, 1'b0, 1'b1);
        check("drop_busy", 32'(ob[1]), 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("drop_ovcnt", 32'(oo[1]), 32'h1);
        check("drop_evcnt", 32'(oe[1]), 32'h1);
        check("drop_busy_end", 32'(ob[1]), 32'h0);
        expq.delete();
        expq.push_back({1'b0, 32'hA5000000});
        for (int k = 1; k <= 14; k++) expq.push_back({1'b0, 32'h200 + 32'(k)});
        expq.push_back({1'b1, 32'h5A01000E});
        drain(1, "fill");

        // MAX_WORDS=8 truncation
        do_reset();
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 32'h300 + 32'(k), 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        expq.delete();
        expq.push_back({1'b0, 32'hA5000000});
        for (int k = 1; k <= 8; k++) expq.push_back({1'b0, 32'h300 + 32'(k)});
        expq.push_back({1'b1, 32'h5A010008});
        drain(2, "trunc");

        // Back-to-back gates with one low cycle between
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h400 + 32'(k), 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h410 + 32'(k), 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("b2b_evcnt", 32'(oe[0]), 32'h2);
        expq.delete();
        expq.push_back({1'b0, 32'hA5000000});
        expq.push_back({1'b0, 32'h401});
        expq.push_back({1'b0, 32'h402});
        expq.push_back({1'b1, 32'h5A000002});
        expq.push_back({1'b0, 32'hA5000001});
        expq.push_back({1'b0, 32'h411});
        expq.push_back({1'b0, 32'h412});
        expq.push_back({1'b1, 32'h5A000002});
        drain(0, "b2b");

        // Reset in the middle of a capture with 5 words buffered
        do_reset();
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 32'h500 + 32'(k), 1'b0, 1'b1);
        check("mid_busy_pre", 32'(ob[0]), 32'h1);
        step(1'b1, 1'b1, 32'h5FF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_valid", 32'(ov[0]), 32'h0);
        check("mid_evcnt", 32'(oe[0]), 32'h0);
        check("mid_ovcnt", 32'(oo[0]), 32'h0);
        check("mid_busy", 32'(ob[0]), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h600, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'h601, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("mid_new_valid", 32'(ov[0]), 32'h1);
        check("mid_new_hdr", od[0], 32'hA5000000);

        // Randomized traffic on the 16-entry instance against the model
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        model_chk = 1'b1;
        rt = 1'b0;
        rphase = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(9, 0) == 0) rt = ~rt;
            if ($urandom_range(24, 0) == 0) rphase = ~rphase;
            step(rt, ($urandom_range(3, 0) != 0), $urandom,
                 rphase && ($urandom_range(3, 0) != 0),
                 ($urandom_range(799, 0) != 0));
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        model_chk = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
